// File: rtl/maple_frame_pattern_detector_if.sv
// Maple frame pattern detector bus interface.
// Bundles the four pre-synchronised SDCKA/SDCKB edge strobes and the
// detector's frame/status outputs.
//   master : drives the edge strobes, observes the detector outputs
//   slave  : the detector itself
interface maple_frame_pattern_detector_if #(
  parameter int CNT_W = 8
);
  logic             sdcka_posedge;
  logic             sdcka_negedge;
  logic             sdckb_posedge;
  logic             sdckb_negedge;
  logic             start_frame;
  logic             end_frame;
  logic             pattern_error;
  logic [1:0]       error_code;
  logic             in_frame;
  logic [CNT_W-1:0] last_count;
  logic             busy;

  modport master (
    output sdcka_posedge, sdcka_negedge, sdckb_posedge, sdckb_negedge,
    input  start_frame, end_frame, pattern_error, error_code,
           in_frame, last_count, busy
  );

  modport slave (
    input  sdcka_posedge, sdcka_negedge, sdckb_posedge, sdckb_negedge,
    output start_frame, end_frame, pattern_error, error_code,
           in_frame, last_count, busy
  );
endinterface

// File: rtl/maple_frame_pattern_detector.sv
// Maple bus start/end-of-frame pattern detector.
// Start: SDCKA held low while SDCKB falls START_PULSES times, then SDCKA rises.
// End  : SDCKB held low while SDCKA falls END_PULSES times, then SDCKB rises.
// Ports:
//   clk   - system clock
//   reset - asynchronous, active-low reset
//   bus   - slave side: edge strobes in; start_frame/end_frame/pattern_error
//           pulses, error_code (01 bad count, 10 timeout, 11 collision or
//           out-of-sequence), in_frame, last_count, busy out.
// All outputs are registered; a hold termination seen in cycle N is reported
// in cycle N+1, when the state is already back in IDLE.
module maple_frame_pattern_detector #(
  parameter int START_PULSES   = 4,
  parameter int END_PULSES     = 2,
  parameter int CNT_W          = 8,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TO_W           = 11
) (
  input  logic                           clk,
  input  logic                           reset,
  maple_frame_pattern_detector_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    HOLD_A = 2'b01,
    HOLD_B = 2'b10
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] START_CNT = CNT_W'(START_PULSES);
  localparam logic [CNT_W-1:0] END_CNT   = CNT_W'(END_PULSES);
  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TO_W-1:0]  to_q, to_d;
  logic             start_frame_q, start_frame_d;
  logic             end_frame_q, end_frame_d;
  logic             pattern_error_q, pattern_error_d;
  logic [1:0]       error_code_q, error_code_d;
  logic             in_frame_q, in_frame_d;
  logic [CNT_W-1:0] last_count_q, last_count_d;
  logic             busy_q, busy_d;

  logic             is_a_s;
  logic             term_s;
  logic [CNT_W-1:0] cnt_next_s;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    sat_inc = (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  // Hold-side decode: which strobe counts and which one ends the hold.
  always_comb begin
    is_a_s     = (state_q == HOLD_A);
    term_s     = 1'b0;
    cnt_next_s = cnt_q;
    if (state_q == HOLD_A) begin
      term_s     = bus.sdcka_posedge;
      cnt_next_s = bus.sdckb_negedge ? sat_inc(cnt_q) : cnt_q;
    end else if (state_q == HOLD_B) begin
      term_s     = bus.sdckb_posedge;
      cnt_next_s = bus.sdcka_negedge ? sat_inc(cnt_q) : cnt_q;
    end else begin
      term_s     = 1'b0;
      cnt_next_s = cnt_q;
    end
  end

  // Next-state, counters and output pulse computation.
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    to_d            = to_q;
    start_frame_d   = 1'b0;
    end_frame_d     = 1'b0;
    pattern_error_d = 1'b0;
    error_code_d    = 2'b00;
    in_frame_d      = in_frame_q;
    last_count_d    = last_count_q;
    case (state_q)
      IDLE: begin
        cnt_d = CNT_ZERO;
        to_d  = {TO_W{1'b0}};
        if (bus.sdcka_negedge && bus.sdckb_negedge) begin
          pattern_error_d = 1'b1;
          error_code_d    = 2'b11;
          in_frame_d      = 1'b0;
        end else if (bus.sdcka_negedge) begin
          state_d = HOLD_A;
        end else if (bus.sdckb_negedge) begin
          state_d = HOLD_B;
        end else begin
          state_d = IDLE;
        end
      end
      HOLD_A, HOLD_B: begin
        if (term_s) begin
          // Termination takes priority over a timeout in the same cycle.
          state_d = IDLE;
          cnt_d   = CNT_ZERO;
          to_d    = {TO_W{1'b0}};
          if (cnt_next_s != CNT_ZERO) begin
            last_count_d = cnt_next_s;
            if (is_a_s && (cnt_next_s == START_CNT)) begin
              if (!in_frame_q) begin
                start_frame_d = 1'b1;
                in_frame_d    = 1'b1;
              end else begin
                pattern_error_d = 1'b1;
                error_code_d    = 2'b11;
              end
            end else if (!is_a_s && (cnt_next_s == END_CNT)) begin
              if (in_frame_q) begin
                end_frame_d = 1'b1;
                in_frame_d  = 1'b0;
              end else begin
                pattern_error_d = 1'b1;
                error_code_d    = 2'b11;
              end
            end else begin
              pattern_error_d = 1'b1;
              error_code_d    = 2'b01;
              in_frame_d      = 1'b0;
            end
          end else begin
            // Zero pulses: an ordinary data bit, nothing to report.
            last_count_d = last_count_q;
          end
        end else if (to_q == TO_LAST) begin
          state_d         = IDLE;
          cnt_d           = CNT_ZERO;
          to_d            = {TO_W{1'b0}};
          pattern_error_d = 1'b1;
          error_code_d    = 2'b10;
          in_frame_d      = 1'b0;
          last_count_d    = cnt_next_s;
        end else begin
          cnt_d = cnt_next_s;
          to_d  = to_q + TO_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = CNT_ZERO;
        to_d    = {TO_W{1'b0}};
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State, counter and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= IDLE;
      cnt_q           <= CNT_ZERO;
      to_q            <= {TO_W{1'b0}};
      start_frame_q   <= 1'b0;
      end_frame_q     <= 1'b0;
      pattern_error_q <= 1'b0;
      error_code_q    <= 2'b00;
      in_frame_q      <= 1'b0;
      last_count_q    <= CNT_ZERO;
      busy_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      to_q            <= to_d;
      start_frame_q   <= start_frame_d;
      end_frame_q     <= end_frame_d;
      pattern_error_q <= pattern_error_d;
      error_code_q    <= error_code_d;
      in_frame_q      <= in_frame_d;
      last_count_q    <= last_count_d;
      busy_q          <= busy_d;
    end
  end

  assign bus.start_frame   = start_frame_q;
  assign bus.end_frame     = end_frame_q;
  assign bus.pattern_error = pattern_error_q;
  assign bus.error_code    = error_code_q;
  assign bus.in_frame      = in_frame_q;
  assign bus.last_count    = last_count_q;
  assign bus.busy          = busy_q;

endmodule
